toggle_gen: RTL and testbench

TOGGLE_GEN -- requirements
Module: toggle_gen

---
 rtl/toggle_gen_pkg.sv | 11 +
 rtl/toggle_chan.sv | 82 ++++++++
 rtl/toggle_gen.sv | 50 +++++
 tb/tb_toggle_gen.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/toggle_gen_pkg.sv
// rtl/toggle_gen_pkg.sv - shared constants and helpers for the toggle generator
package toggle_gen_pkg;

  localparam int MAX_CHANNELS = 16;
  localparam int WR_CH_W      = 4;

  function automatic logic ch_in_range(input logic [WR_CH_W-1:0] ch, input int channels);
    return int'(ch) < channels;
  endfunction

endpackage

// File: rtl/toggle_chan.sv
// rtl/toggle_chan.sv - one toggle channel: half-period register, counter, out and edge (TOGGLE_GEN_INV_EN adds out_n_o)
module toggle_chan
  import toggle_gen_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DEFAULT_HALF = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             out_o,
`ifdef TOGGLE_GEN_INV_EN
  output logic             out_n_o,
`endif
  output logic             edge_o
);

  logic [WIDTH-1:0] hp_q, hp_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             edge_q, edge_d;
  logic             terminal;

  assign terminal = (cnt_q == hp_q - WIDTH'(1));

  // Clear beats write beats terminal count; hp=0 parks the channel.
  always_comb begin
    hp_d   = wr_i ? wr_data_i : hp_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    edge_d = 1'b0;
    if (sync_clr) begin
      cnt_d = '0;
      out_d = 1'b0;
    end else if (wr_i) begin
      cnt_d = '0;
    end else if (en && (hp_q != '0)) begin
      if (terminal) begin
        cnt_d  = '0;
        out_d  = ~out_q;
        edge_d = 1'b1;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hp_q   <= WIDTH'(DEFAULT_HALF);
      cnt_q  <= '0;
      out_q  <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      hp_q   <= hp_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      edge_q <= edge_d;
    end
  end

`ifdef TOGGLE_GEN_INV_EN
  logic out_n_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_n_q <= 1'b1;
    end else begin
      out_n_q <= ~out_d;
    end
  end

  assign out_n_o = out_n_q;
`endif

  assign out_o  = out_q;
  assign edge_o = edge_q;

endmodule

// File: rtl/toggle_gen.sv
// rtl/toggle_gen.sv - multi-channel square-wave generator top: write decode and channel fan-out (TOGGLE_GEN_INV_EN adds out_n)
module toggle_gen
  import toggle_gen_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int WIDTH        = 8,
  parameter int DEFAULT_HALF = 30
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 sync_clr,
  input  logic                 wr_en,
  input  logic [WR_CH_W-1:0]   wr_ch,
  input  logic [WIDTH-1:0]     wr_data,
  output logic [CHANNELS-1:0]  out,
`ifdef TOGGLE_GEN_INV_EN
  output logic [CHANNELS-1:0]  out_n,
`endif
  output logic [CHANNELS-1:0]  edge_o
);

  logic wr_hit;

  assign wr_hit = wr_en && ch_in_range(wr_ch, CHANNELS);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic wr_sel;

    assign wr_sel = wr_hit && (int'(wr_ch) == g);

    toggle_chan #(
      .WIDTH        (WIDTH),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .sync_clr  (sync_clr),
      .wr_i      (wr_sel),
      .wr_data_i (wr_data),
      .out_o     (out[g]),
`ifdef TOGGLE_GEN_INV_EN
      .out_n_o   (out_n[g]),
`endif
      .edge_o    (edge_o[g])
    );
  end

endmodule

// File: tb/tb_toggle_gen.sv
// tb/tb_toggle_gen.sv - self-checking bench for toggle_gen against an elapsed-cycle model
module tb_toggle_gen;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int DH = 30;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          sync_clr = 1'b0;
  logic          wr_en = 1'b0;
  logic [3:0]    wr_ch = '0;
  logic [W-1:0]  wr_data = '0;
  logic [CH-1:0] out;
  logic [CH-1:0] edge_o;
`ifdef TOGGLE_GEN_INV_EN
  logic [CH-1:0] out_n;
`endif

  always #5 clk = ~clk;

  toggle_gen #(
    .CHANNELS     (CH),
    .WIDTH        (W),
    .DEFAULT_HALF (DH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sync_clr (sync_clr),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_data  (wr_data),
    .out      (out),
`ifdef TOGGLE_GEN_INV_EN
    .out_n    (out_n),
`endif
    .edge_o   (edge_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int            m_hp[CH];
  int            m_elapsed[CH];
  logic [CH-1:0] m_out;
  logic [CH-1:0] m_edge;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_hp[c]      = DH;
      m_elapsed[c] = 0;
    end
    m_out  = '0;
    m_edge = '0;
  endtask

  // Each channel counts enabled cycles since its last restart and flips when that reaches hp.
  task automatic model_update();
    for (int c = 0; c < CH; c++) begin
      bit hit;
      hit = wr_en && (int'(wr_ch) == c);
      m_edge[c] = 1'b0;
      if (sync_clr) begin
        m_elapsed[c] = 0;
        m_out[c]     = 1'b0;
      end else if (hit) begin
        m_elapsed[c] = 0;
      end else if (en && m_hp[c] != 0) begin
        m_elapsed[c]++;
        if (m_elapsed[c] == m_hp[c]) begin
          m_elapsed[c] = 0;
          m_out[c]     = ~m_out[c];
          m_edge[c]    = 1'b1;
        end
      end
      if (hit) m_hp[c] = int'(wr_data);
    end
  endtask

  task automatic compare();
    check("out_vs_model", out, m_out);
    check("edge_vs_model", edge_o, m_edge);
`ifdef TOGGLE_GEN_INV_EN
    check("out_n_vs_model", out_n, ~m_out);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_update();
    @(negedge clk);
    compare();
  endtask

  initial begin
    logic [CH-1:0] edge_acc;

    model_reset();
    @(negedge clk);
    check("reset_out", out, 0);
    check("reset_edge", edge_o, 0);
`ifdef TOGGLE_GEN_INV_EN
    check("reset_out_n", out_n, 4'hF);
`endif
    compare();
    rst_n = 1'b1;
    step();
    step();
    check("hold_before_en", out, 0);

    en = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (k == 29) check("c0_out_at_29", out[0], 0);
      if (k == 30) begin
        check("c0_out_at_30", out[0], 1);
        check("c0_edge_at_30", edge_o[0], 1);
      end
      if (k == 31) check("c0_edge_at_31", edge_o[0], 0);
      if (k == 59) check("c0_out_at_59", out[0], 1);
      if (k == 60) begin
        check("c0_out_at_60", out[0], 0);
        check("c0_edge_at_60", edge_o[0], 1);
      end
    end

    repeat (5) step();
    wr_en = 1'b1; wr_ch = 4'd2; wr_data = 8'd3;
    step();
    wr_en = 1'b0;
    check("c2_after_write", out[2], 0);
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 2) check("c2_out_k2", out[2], 0);
      if (k == 3) begin
        check("c2_out_k3", out[2], 1);
        check("c2_edge_k3", edge_o[2], 1);
      end
      if (k == 6) check("c2_out_k6", out[2], 0);
    end

    wr_en = 1'b1; wr_ch = 4'd1; wr_data = 8'd0;
    step();
    wr_en = 1'b0;
    edge_acc = '0;
    repeat (100) begin
      step();
      edge_acc = edge_acc | edge_o;
    end
    check("c1_frozen_out", out[1], 0);
    check("c1_frozen_edge", edge_acc[1], 0);
    wr_en = 1'b1; wr_ch = 4'd1; wr_data = 8'd1;
    step();
    wr_en = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("c1_hp1_out", out[1], k % 2);
      check("c1_hp1_edge", edge_o[1], 1);
    end

    sync_clr = 1'b1; wr_en = 1'b1; wr_ch = 4'd0; wr_data = 8'd4;
    step();
    sync_clr = 1'b0; wr_en = 1'b0;
    check("clr_out", out, 0);
    check("clr_edge", edge_o, 0);
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 3) check("c0_hp4_k3", out[0], 0);
      if (k == 4) begin
        check("c0_hp4_k4", out[0], 1);
        check("c0_hp4_edge", edge_o[0], 1);
      end
    end
    wr_en = 1'b1; wr_ch = 4'd15; wr_data = 8'd1;
    step();
    wr_en = 1'b0;
    repeat (3) step();

    sync_clr = 1'b1; wr_en = 1'b1; wr_ch = 4'd3; wr_data = 8'd8;
    step();
    sync_clr = 1'b0; wr_en = 1'b0;
    repeat (5) step();
    en = 1'b0;
    edge_acc = '0;
    repeat (10) begin
      step();
      edge_acc = edge_acc | edge_o;
    end
    check("en0_edges", edge_acc, 0);
    check("en0_c3_out", out[3], 0);
    en = 1'b1;
    step();
    step();
    check("c3_resume_k2", out[3], 0);
    step();
    check("c3_resume_k3", out[3], 1);
    check("c3_resume_edge", edge_o[3], 1);

    for (int i = 0; i < 600; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      sync_clr = ($urandom_range(0, 63) == 0);
      wr_en    = ($urandom_range(0, 9) == 0);
      wr_ch    = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      wr_data  = W'($urandom_range(0, 9));
      step();
    end
    en = 1'b1; sync_clr = 1'b0; wr_en = 1'b0;
    repeat (2) step();

    #7;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", out, 0);
    check("async_rst_edge", edge_o, 0);
`ifdef TOGGLE_GEN_INV_EN
    check("async_rst_out_n", out_n, 4'hF);
`endif
    model_reset();
    @(negedge clk);
    compare();
    rst_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 29) check("post_rst_out_29", out[0], 0);
      if (k == 30) begin
        check("post_rst_out_30", out[0], 1);
        check("post_rst_edge_30", edge_o[0], 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
